vga_text_writer: RTL

Upstream feeder for the VGA text-mode character buffer (dual-port sync RAM, write/read port A). It accepts ASCII characters over a valid/ready handshake and maintains a cursor. It writes glyph codes into the buffer and handles control codes: CR, LF, BS and FF. When output runs past the last row, it scrolls the screen by copying rows through port A. Port B stays owned by the pixel/font readout stage.

---
 rtl/vga_text_writer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vga_text_writer.sv
// Character feeder for the VGA text buffer: owns buffer port A, tracks the cursor,
// handles CR/LF/BS/FF and scrolls by copying each row up one line.
module vga_text_writer #(
  parameter int COLS       = 32,
  parameter int ROWS       = 30,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    char_valid,
  input  logic [DATA_WIDTH-1:0]   char_data,
  output logic                    char_ready,
  output logic                    busy,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  input  logic [DATA_WIDTH-1:0]   ram_dout,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(COLS*ROWS-1);
  localparam logic [ADDR_WIDTH-1:0] SCR_LAST = ADDR_WIDTH'((ROWS-1)*COLS-1);
  localparam logic [ADDR_WIDTH-1:0] SCR_BASE = ADDR_WIDTH'((ROWS-1)*COLS);
  localparam logic [ADDR_WIDTH-1:0] COLS_A   = ADDR_WIDTH'(COLS);
  localparam logic [COL_W-1:0]      COL_MAX  = COL_W'(COLS-1);
  localparam logic [ROW_W-1:0]      ROW_MAX  = ROW_W'(ROWS-1);
  localparam logic [DATA_WIDTH-1:0] SPACE    = DATA_WIDTH'(8'h20);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_WRITE, S_SCR_RD, S_SCR_WR, S_SCR_CLR
  } state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   idx, idx_n;
  logic [COL_W-1:0]        col, col_n;
  logic [ROW_W-1:0]        row, row_n;
  logic [DATA_WIDTH-1:0]   ch, ch_n;
  logic                    adv, adv_n;   // WRITE advances cursor (clear for BS erase)
  logic                    we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   din;
  logic [ADDR_WIDTH-1:0]   cur_addr;

  assign cur_addr = ADDR_WIDTH'(row) * COLS_A + ADDR_WIDTH'(col);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_CLEAR;
      idx   <= '0;
      col   <= '0;
      row   <= '0;
      ch    <= SPACE;
      adv   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      col   <= col_n;
      row   <= row_n;
      ch    <= ch_n;
      adv   <= adv_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    col_n   = col;
    row_n   = row;
    ch_n    = ch;
    adv_n   = adv;
    we      = 1'b0;
    addr    = idx;
    din     = SPACE;
    case (state)
      S_CLEAR: begin
        we = 1'b1;
        if (idx == LAST) begin
          state_n = S_IDLE;
          idx_n   = '0;
          col_n   = '0;
          row_n   = '0;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      S_IDLE: begin
        if (char_valid) begin
          if (char_data >= DATA_WIDTH'(8'h20) && char_data <= DATA_WIDTH'(8'h7E)) begin
            ch_n    = char_data;
            adv_n   = 1'b1;
            state_n = S_WRITE;
          end else if (char_data == DATA_WIDTH'(8'h0D)) begin
            col_n = '0;
          end else if (char_data == DATA_WIDTH'(8'h0A)) begin
            col_n = '0;
            if (row != ROW_MAX) begin
              row_n = row + 1'b1;
            end else begin
              idx_n   = '0;
              state_n = S_SCR_RD;
            end
          end else if (char_data == DATA_WIDTH'(8'h08)) begin
            if (col != '0) begin
              col_n   = col - 1'b1;
              ch_n    = SPACE;
              adv_n   = 1'b0;
              state_n = S_WRITE;
            end
          end else if (char_data == DATA_WIDTH'(8'h0C)) begin
            idx_n   = '0;
            state_n = S_CLEAR;
          end
        end
      end
      S_WRITE: begin
        we      = 1'b1;
        addr    = cur_addr;
        din     = ch;
        state_n = S_IDLE;
        if (adv) begin
          if (col != COL_MAX) begin
            col_n = col + 1'b1;
          end else begin
            col_n = '0;
            if (row != ROW_MAX) begin
              row_n = row + 1'b1;
            end else begin
              idx_n   = '0;
              state_n = S_SCR_RD;
            end
          end
        end
      end
      S_SCR_RD: begin
        addr    = idx + COLS_A;
        state_n = S_SCR_WR;
      end
      // ram_dout here holds the source cell addressed during the preceding SCR_RD
      S_SCR_WR: begin
        we  = 1'b1;
        din = ram_dout;
        if (idx == SCR_LAST) begin
          idx_n   = SCR_BASE;
          state_n = S_SCR_CLR;
        end else begin
          idx_n   = idx + 1'b1;
          state_n = S_SCR_RD;
        end
      end
      S_SCR_CLR: begin
        we = 1'b1;
        if (idx == LAST) begin
          state_n = S_IDLE;
          idx_n   = '0;
          col_n   = '0;
          row_n   = ROW_MAX;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      default: begin
        state_n = S_CLEAR;
        idx_n   = '0;
      end
    endcase
  end

  // Reset forces the externally visible outputs quiet in the same cycle
  assign ram_we     = resetn & we;
  assign ram_addr   = addr;
  assign ram_din    = din;
  assign char_ready = resetn & (state == S_IDLE);
  assign busy       = ~resetn | (state != S_IDLE);
  assign cursor_col = resetn ? col : '0;
  assign cursor_row = resetn ? row : '0;
endmodule
